// File: rtl/usb_pkg.sv
// Shared line encodings, state type and NRZI helper for the USB transmit path.
package usb_pkg;

    localparam logic [7:0] SYNC_BYTE = 8'h80;

    // Line symbols packed as {d_plus, d_minus}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } tx_state_t;

    // NRZI: a 1 holds the current level, a 0 toggles J<->K
    function automatic logic [1:0] nrzi(input logic [1:0] level, input logic bit_v);
        return bit_v ? level : ((level == LINE_J) ? LINE_K : LINE_J);
    endfunction

endpackage

// File: rtl/usb_tx_bit_timer.sv
// Modulo-CLKS_PER_BIT bit-period counter with boundary and one-early strobes.
module usb_tx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic boundary_c,
    output logic pre_boundary_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign boundary_c     = en && (cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign pre_boundary_c = en && (cnt_q == CNT_W'(CLKS_PER_BIT - 2));

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = boundary_c ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// Full-speed USB transmitter: SYNC, bit stuffing, NRZI line drive and EOP.
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned STUFF_LIMIT  = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_data_last,
    output logic       tx_data_ready,
    output logic       d_plus_out,
    output logic       d_minus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_underrun
);

    localparam int unsigned STUFF_W = $clog2(STUFF_LIMIT + 1);

    tx_state_t          state_q,     state_d;
    logic [7:0]         shift_q,     shift_d;
    logic [2:0]         bit_cnt_q,   bit_cnt_d;
    logic [STUFF_W-1:0] stuff_cnt_q, stuff_cnt_d;
    logic               last_q,      last_d;
    logic               byte_end_q,  byte_end_d;
    logic [1:0]         line_q,      line_d;
    logic               busy_q,      busy_d;
    logic               ready_q,     ready_d;
    logic               done_q,      done_d;
    logic               underrun_q,  underrun_d;

    logic               boundary_c;
    logic               pre_boundary_c;
    logic [STUFF_W-1:0] stuff_inc_c;
    logic               stuff_hit_c;
    logic               byte_end_now_c;

    usb_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk           (clk),
        .rst           (rst),
        .en            (state_q != IDLE),
        .clr           (state_q == IDLE),
        .boundary_c    (boundary_c),
        .pre_boundary_c(pre_boundary_c)
    );

    // Stuff decision for the bit currently on the line; constant over its period
    assign stuff_inc_c    = shift_q[0] ? stuff_cnt_q + STUFF_W'(1) : '0;
    assign stuff_hit_c    = (state_q == DATA) && (stuff_inc_c == STUFF_W'(STUFF_LIMIT));
    assign byte_end_now_c = (((state_q == SYNC) || (state_q == DATA)) &&
                             (bit_cnt_q == 3'd7) && !stuff_hit_c) ||
                            ((state_q == STUFF) && byte_end_q);

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        stuff_cnt_d = stuff_cnt_q;
        last_d      = last_q;
        byte_end_d  = byte_end_q;
        line_d      = line_q;
        ready_d     = 1'b0;
        done_d      = 1'b0;
        underrun_d  = 1'b0;

        // Ready is registered, so it is raised one cycle ahead of the fetch boundary
        ready_d = pre_boundary_c && byte_end_now_c && !last_q;
        done_d  = pre_boundary_c && (state_q == EOP_J);

        case (state_q)
            IDLE: begin
                line_d = LINE_J;
                if (tx_start) begin
                    state_d     = SYNC;
                    shift_d     = SYNC_BYTE;
                    bit_cnt_d   = 3'd0;
                    stuff_cnt_d = '0;
                    last_d      = 1'b0;
                    byte_end_d  = 1'b0;
                    line_d      = nrzi(LINE_J, SYNC_BYTE[0]);
                end
            end
            SYNC, DATA: begin
                if (boundary_c) begin
                    stuff_cnt_d = stuff_inc_c;
                    if (stuff_hit_c) begin
                        state_d     = STUFF;
                        stuff_cnt_d = '0;
                        byte_end_d  = (bit_cnt_q == 3'd7);
                        line_d      = nrzi(line_q, 1'b0);
                        if (bit_cnt_q != 3'd7) begin
                            shift_d   = {1'b0, shift_q[7:1]};
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else if (bit_cnt_q != 3'd7) begin
                        shift_d   = {1'b0, shift_q[7:1]};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        line_d    = nrzi(line_q, shift_q[1]);
                    end
                end
            end
            STUFF: begin
                if (boundary_c && !byte_end_q) begin
                    state_d = DATA;
                    line_d  = nrzi(line_q, shift_q[0]);
                end
            end
            EOP_SE0: begin
                if (boundary_c) begin
                    if (bit_cnt_q == 3'd1) begin
                        state_d = EOP_J;
                        line_d  = LINE_J;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (boundary_c) begin
                    state_d = IDLE;
                    line_d  = LINE_J;
                end
            end
            default: begin
                state_d = IDLE;
                line_d  = LINE_J;
            end
        endcase

        // Byte fetch or packet end, shared by SYNC/DATA end and a trailing stuff bit
        if (boundary_c && byte_end_now_c) begin
            byte_end_d = 1'b0;
            bit_cnt_d  = 3'd0;
            if (!last_q && tx_data_valid) begin
                state_d = DATA;
                shift_d = tx_data;
                last_d  = tx_data_last;
                line_d  = nrzi(line_q, tx_data[0]);
            end else begin
                state_d    = EOP_SE0;
                line_d     = LINE_SE0;
                underrun_d = !last_q;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            stuff_cnt_q <= '0;
            last_q      <= 1'b0;
            byte_end_q  <= 1'b0;
            line_q      <= LINE_J;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            stuff_cnt_q <= stuff_cnt_d;
            last_q      <= last_d;
            byte_end_q  <= byte_end_d;
            line_q      <= line_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign d_plus_out    = line_q[1];
    assign d_minus_out   = line_q[0];
    assign tx_busy       = busy_q;
    assign tx_data_ready = ready_q;
    assign tx_done       = done_q;
    assign tx_underrun   = underrun_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Scoreboard bench for usb_tx_encoder: bit-level reference model vs. sampled line.
module tb_usb_tx_encoder;

    localparam int CPB   = 8;
    localparam int LIMIT = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_data_last;
    logic       tx_data_ready;
    logic       d_plus_out;
    logic       d_minus_out;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_underrun;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB), .STUFF_LIMIT(LIMIT)) dut (
        .clk          (clk),
        .rst          (rst),
        .tx_start     (tx_start),
        .tx_data      (tx_data),
        .tx_data_valid(tx_data_valid),
        .tx_data_last (tx_data_last),
        .tx_data_ready(tx_data_ready),
        .d_plus_out   (d_plus_out),
        .d_minus_out  (d_minus_out),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_underrun  (tx_underrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int len;
        int n_ready;
        int n_under;
        int under_cyc;
        int done_cyc;
        int ready0;
    } exp_t;

    exp_t       exp_q[$];
    logic [1:0] sym_q[$];
    int         checks   = 0;
    int         failures = 0;
    bit         mon_en   = 1'b1;
    int         pkt_no   = 0;

    task automatic check(input string name, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    // Reference: bit list -> stuffing -> NRZI symbols, plus packet-level expectations
    task automatic push_expected(input logic [7:0] b[$], input int nv);
        int         bits[$];
        int         ones;
        int         m;
        bit         under;
        logic [7:0] cur;
        logic [1:0] lvl;
        exp_t       e;
        cur  = 8'h80;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            bits.push_back(int'(cur[i]));
            ones = cur[i] ? ones + 1 : 0;
        end
        under = (nv < b.size());
        m     = under ? nv : b.size();
        for (int k = 0; k < m; k++) begin
            cur = b[k];
            for (int i = 0; i < 8; i++) begin
                bits.push_back(int'(cur[i]));
                ones = cur[i] ? ones + 1 : 0;
                if (ones == LIMIT) begin
                    bits.push_back(0);
                    ones = 0;
                end
            end
        end
        lvl = 2'b10;
        foreach (bits[j]) begin
            if (bits[j] == 0) lvl = (lvl == 2'b10) ? 2'b01 : 2'b10;
            sym_q.push_back(lvl);
        end
        sym_q.push_back(2'b00);
        sym_q.push_back(2'b00);
        sym_q.push_back(2'b10);
        e.len       = (bits.size() + 3) * CPB;
        e.n_ready   = under ? m + 1 : b.size();
        e.n_under   = under ? 1 : 0;
        e.under_cyc = under ? bits.size() * CPB : -1;
        e.done_cyc  = e.len - 1;
        e.ready0    = 8 * CPB - 1;
        exp_q.push_back(e);
    endtask

    task automatic drive_byte(input logic [7:0] b[$], input int nv, input int idx);
        if (idx < b.size() && idx < nv) begin
            tx_data       = b[idx];
            tx_data_valid = 1'b1;
            tx_data_last  = (idx == b.size() - 1);
        end else begin
            tx_data       = 8'($urandom);
            tx_data_valid = 1'b0;
            tx_data_last  = 1'b0;
        end
    endtask

    task automatic run_packet(input logic [7:0] b[$], input int nv, input bit poke);
        int idx;
        bit adv;
        int t;
        push_expected(b, nv);
        @(negedge clk);
        idx = 0;
        drive_byte(b, nv, idx);
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        adv = 1'b0;
        t   = 0;
        while (tx_busy && t < 4000) begin
            if (adv) begin
                idx++;
                drive_byte(b, nv, idx);
                adv = 1'b0;
            end
            if (tx_data_ready && tx_data_valid) adv = 1'b1;
            tx_start = poke && (t == 100 || t == 250);
            @(negedge clk);
            t++;
        end
        tx_start      = 1'b0;
        tx_data_valid = 1'b0;
        if (t >= 4000) check("packet_timeout", 1, 0);
        repeat (3) @(negedge clk);
    endtask

    // Monitor: per-bit line symbols and per-packet pulse accounting
    initial begin : monitor
        bit         active;
        int         cyc, nr, nu, ucyc, nd, dcyc, r0;
        logic [1:0] first, line, es;
        bit         stable;
        exp_t       e;
        active = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 1'b0;
                continue;
            end
            if (!active && tx_busy && mon_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_packet", 1, 0);
                    e = '{-1, -1, -1, -1, -1, -1};
                end else begin
                    e = exp_q.pop_front();
                end
                active = 1'b1;
                cyc = 0; nr = 0; nu = 0; nd = 0;
                ucyc = -1; dcyc = -1; r0 = -1;
                pkt_no++;
            end
            if (active) begin
                if (!tx_busy) begin
                    check($sformatf("pkt%0d busy_len", pkt_no), cyc, e.len);
                    check($sformatf("pkt%0d ready_count", pkt_no), nr, e.n_ready);
                    check($sformatf("pkt%0d first_ready_cyc", pkt_no), r0, e.ready0);
                    check($sformatf("pkt%0d underrun_count", pkt_no), nu, e.n_under);
                    check($sformatf("pkt%0d underrun_cyc", pkt_no), ucyc, e.under_cyc);
                    check($sformatf("pkt%0d done_count", pkt_no), nd, 1);
                    check($sformatf("pkt%0d done_cyc", pkt_no), dcyc, e.done_cyc);
                    check($sformatf("pkt%0d leftover_symbols", pkt_no), sym_q.size(), 0);
                    sym_q.delete();
                    active = 1'b0;
                end else begin
                    line = {d_plus_out, d_minus_out};
                    if (cyc % CPB == 0) begin
                        first  = line;
                        stable = 1'b1;
                    end else if (line != first) begin
                        stable = 1'b0;
                    end
                    if (cyc % CPB == CPB - 1) begin
                        if (sym_q.size() == 0) begin
                            check($sformatf("pkt%0d symbol_overrun", pkt_no), 1, 0);
                        end else begin
                            es = sym_q.pop_front();
                            check($sformatf("pkt%0d bit%0d line{stable,dp,dm}", pkt_no, cyc / CPB),
                                  int'({stable, first}), int'({1'b1, es}));
                        end
                    end
                    if (tx_data_ready) begin
                        if (nr == 0) r0 = cyc;
                        nr++;
                    end
                    if (tx_underrun) begin
                        nu++;
                        ucyc = cyc;
                    end
                    if (tx_done) begin
                        nd++;
                        dcyc = cyc;
                    end
                    cyc++;
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        logic [7:0] pk[$];
        int bad;
        int sz;
        int nv;
        rst           = 1'b1;
        tx_start      = 1'b0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        tx_data_last  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset d_plus", int'(d_plus_out), 1);
        check("reset d_minus", int'(d_minus_out), 0);
        check("reset busy", int'(tx_busy), 0);
        check("reset ready", int'(tx_data_ready), 0);
        check("reset done_underrun", int'({tx_done, tx_underrun}), 0);
        rst = 1'b0;

        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if ({d_plus_out, d_minus_out} != 2'b10 || tx_busy || tx_data_ready ||
                tx_done || tx_underrun) bad++;
        end
        check("idle_cycles_bad", bad, 0);

        pk = '{8'h2D};             run_packet(pk, 1, 1'b0);
        pk = '{8'hFF, 8'h00};      run_packet(pk, 2, 1'b0);
        pk = '{8'h3F};             run_packet(pk, 1, 1'b0);
        pk = '{8'hFC};             run_packet(pk, 1, 1'b0);
        pk = '{8'hFC, 8'h01};      run_packet(pk, 2, 1'b1);
        pk = '{8'h12, 8'h34};      run_packet(pk, 1, 1'b0);
        pk = '{8'hA5};             run_packet(pk, 0, 1'b0);
        pk = '{8'hFF, 8'hFF, 8'hFF}; run_packet(pk, 3, 1'b0);

        for (int n = 0; n < 10; n++) begin
            pk.delete();
            sz = $urandom_range(1, 4);
            for (int i = 0; i < sz; i++)
                pk.push_back(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom));
            nv = ($urandom_range(0, 4) == 0) ? $urandom_range(0, sz - 1) : sz;
            run_packet(pk, nv, n[0]);
        end

        // Abort in the middle of DATA: no EOP, no done, line straight back to J
        mon_en = 1'b0;
        @(negedge clk);
        tx_data       = 8'hA5;
        tx_data_valid = 1'b1;
        tx_data_last  = 1'b0;
        tx_start      = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (8 * CPB + 30) @(negedge clk);
        tx_data_valid = 1'b0;
        check("pre_abort busy", int'(tx_busy), 1);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort line", int'({d_plus_out, d_minus_out}), int'(2'b10));
        check("abort busy", int'(tx_busy), 0);
        bad = 0;
        repeat (3) begin
            @(negedge clk);
            if (tx_done) bad++;
        end
        rst = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (tx_done || tx_busy || {d_plus_out, d_minus_out} != 2'b10) bad++;
        end
        check("post_abort_quiet", bad, 0);
        mon_en = 1'b1;

        pk = '{8'h69, 8'hC3};      run_packet(pk, 2, 1'b0);

        check("packets_pending", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
